bitwise_issuer: RTL and testbench
=================================

# bitwise_issuer

Sequential initiator for the 16-bit combinational bitwise unit (`op` 0 = AND, 1 = OR, 2 = invert `a`). It accepts commands over a valid/ready interface and drives operands and opcode into the unit. It waits a programmable settle time, then captures the unit's output into an accumulator and returns it over a valid/ready result interface. It sits between the lab's command source and the bitwise unit, and is the driving end of that unit's `a`/`b`/`op`/`out` interface.

## Interface
- `SETTLE`, 1: cycles `alu_a`/`alu_b`/`alu_op` are held before `alu_out` is sampled; legal 1..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_op` input 2: 0 = AND, 1 = OR, 2 = INV, 3 = LOAD.
- `cmd_data` input 16: operand (`b` for AND/OR; load value for LOAD; ignored for INV).
- `alu_a` output 16: to bitwise unit `a`.
- `alu_b` output 16: to bitwise unit `b`.
- `alu_op` output 2: to bitwise unit `op`; only 0, 1, 2 are ever driven.
- `alu_out` input 16: from bitwise unit `out`.
- `res_valid` output 1: result present.
- `res_ready` input 1: consumer accepts result.
- `res_data` output 16: result value.
- `acc` output 16: current accumulator.
- `busy` output 1: state is not IDLE.
- `err` output 1: sticky result-mismatch flag (see Configuration).

## Operation
- **Reset values:**
  - State IDLE; `acc` = 0, `res_data` = 0, `res_valid` = 0.
  - `alu_a` = 0, `alu_b` = 0, `alu_op` = 0.
  - `busy` = 0, `err` = 0.
  - `cmd_ready` = 1 once out of reset.
- **States:**
  - **IDLE:**
    - `cmd_ready` = 1.
    - A handshake (`cmd_valid` & `cmd_ready`) with LOAD sets `acc <= cmd_data` and the block stays in IDLE. LOAD produces no result.
    - A handshake with AND/OR/INV registers `alu_a <= acc`, `alu_b <= cmd_data` (0 for INV) and `alu_op <= cmd_op` (2 for INV). It clears the settle counter and moves to ISSUE.
  - **ISSUE:**
    - Operands held stable; the counter increments each cycle.
    - On the edge ending the SETTLE-th ISSUE cycle: `acc <= alu_out`, `res_data <= alu_out`, `res_valid <= 1`, `alu_op <= 0`, go to RESP.
  - **RESP:**
    - `res_valid` = 1 and `res_data` stay stable until `res_ready`.
    - On handshake: `res_valid <= 0`, go to IDLE.
- `cmd_ready` = (state == IDLE). Commands are never accepted in ISSUE or RESP, so there is at most one operation in flight.
- `alu_a`/`alu_b` keep their last values after ISSUE. Only `alu_op` returns to 0.
- Accumulator arithmetic is pure 16-bit bitwise. There is no carry and no width growth.
- `cmd_op` = 3 is never forwarded to `alu_op`.

## Timing
- LOAD: `acc` updates on the accept edge. A new command can be accepted on the very next cycle.
- AND/OR/INV:
  - Accept edge at cycle 0.
  - ISSUE occupies cycles 1..SETTLE.
  - `res_valid` rises in cycle SETTLE+1.
  - `acc` shows the new value in the same cycle.
- Best-case throughput is one op per SETTLE+2 cycles, with `res_ready` held high.
- `res_ready` asserted in the same cycle `res_valid` rises completes the handshake at that edge. IDLE and `cmd_ready` = 1 follow in the next cycle.
- `res_ready` asserted while `res_valid` = 0 is ignored.
- `rst_n` low in any state immediately forces all reset values. Any in-flight op or pending result is discarded without a handshake.
- `cmd_valid` held high while `cmd_ready` = 0 has no effect. The command must be held until accepted.

## Configuration
- **`BITWISE_ISSUER_CHECK_EN` defined:**
  - At the capture edge the block computes the expected value internally (`acc & b`, `acc | b`, `~acc`) and compares it with `alu_out`.
  - A mismatch sets `err`, which stays 1 until reset.
  - `res_data` still carries `alu_out`.
- **Undefined:** no checker logic; `err` is tied to 0.

## Test plan
- **Reset, then LOAD:** reset, then LOAD 16'hF0F0 → `acc` = 16'hF0F0 the next cycle, `res_valid` stays 0, `cmd_ready` stays 1.
- **AND:**
  - Stimulus: LOAD 16'hF0F0, then AND 16'h3C3C, SETTLE = 1, `res_ready` = 1.
  - Response: in cycle 1 `alu_a` = F0F0, `alu_b` = 3C3C, `alu_op` = 0; `res_valid` rises in cycle 2 with `res_data` = 16'h3030.
- **OR then INV:** from `acc` = 16'h3030, OR 16'h000F → 16'h303F; then INV → 16'hCFC0 with `alu_op` = 2 during ISSUE.
- **Backpressure:** SETTLE = 3, `res_ready` = 0 for 5 cycles → `res_valid` rises 4 cycles after accept and `res_data` stays stable. `cmd_ready` stays 0 until the cycle after `res_ready` rises.
- **Reset mid-op:** assert `rst_n` low during ISSUE → all outputs return to reset values asynchronously; after release `acc` = 0 and IDLE.
- **Checker (`BITWISE_ISSUER_CHECK_EN`):**
  - Model returns 16'h0000 instead of the correct result for AND F0F0 & 3C3C → `err` = 1, and stays 1 through later correct ops until reset.
  - Without the macro, `err` = 0.

Source files
------------

// File: rtl/bitwise_issuer.sv
// Sequential initiator for the 16-bit bitwise unit: accepts AND/OR/INV/LOAD commands,
// holds operands for SETTLE cycles, captures the result. Optional checker: BITWISE_ISSUER_CHECK_EN.
module bitwise_issuer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [15:0] cmd_data_i,
    output logic [15:0] alu_a_o,
    output logic [15:0] alu_b_o,
    output logic [1:0]  alu_op_o,
    input  logic [15:0] alu_out_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [15:0] res_data_o,
    output logic [15:0] acc_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] OP_INV  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] res_data_q, res_data_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        accept, capture;

    assign accept  = (state_q == S_IDLE) && cmd_valid_i;
    assign capture = (state_q == S_ISSUE) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op_i == OP_LOAD) begin
                        acc_d = cmd_data_i;
                    end else begin
                        alu_a_d  = acc_q;
                        alu_b_d  = (cmd_op_i == OP_INV) ? 16'h0000 : cmd_data_i;
                        alu_op_d = cmd_op_i;
                        cnt_d    = 4'd0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (capture) begin
                    acc_d       = alu_out_i;
                    res_data_d  = alu_out_i;
                    res_valid_d = 1'b1;
                    alu_op_d    = 2'd0;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            acc_q       <= 16'h0000;
            res_data_q  <= 16'h0000;
            res_valid_q <= 1'b0;
            alu_a_q     <= 16'h0000;
            alu_b_q     <= 16'h0000;
            alu_op_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
        end
    end

`ifdef BITWISE_ISSUER_CHECK_EN
    // Reference result from the held operands; any disagreement at capture latches err.
    logic [15:0] exp_out;
    logic        err_q, err_d;

    always_comb begin
        case (alu_op_q)
            2'd0:    exp_out = alu_a_q & alu_b_q;
            2'd1:    exp_out = alu_a_q | alu_b_q;
            default: exp_out = ~alu_a_q;
        endcase
        err_d = err_q | (capture && (alu_out_i != exp_out));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign acc_o       = acc_q;
endmodule

// File: tb/tb_bitwise_issuer.sv
// Directed bench for bitwise_issuer: one instance with SETTLE=1, one with SETTLE=3,
// each driving a behavioural bitwise unit (the first can be forced to return 0).
module tb_bitwise_issuer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = 16'h0000;

    logic        v1 = 1'b0, rr1 = 1'b0, bad1 = 1'b0;
    logic        crdy1, rv1, busy1, err1;
    logic [15:0] a1, b1, out1, rd1, acc1;
    logic [1:0]  op1;

    logic        v3 = 1'b0, rr3 = 1'b0;
    logic        crdy3, rv3, busy3, err3;
    logic [15:0] a3, b3, out3, rd3, acc3;
    logic [1:0]  op3;

    int n_chk = 0;
    int n_pass = 0;
    logic exp_err;

    always #5 clk = ~clk;

    function automatic logic [15:0] unit(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            default: return ~a;
        endcase
    endfunction

    assign out1 = bad1 ? 16'h0000 : unit(a1, b1, op1);
    assign out3 = unit(a3, b3, op3);

    bitwise_issuer #(.SETTLE(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(v1), .cmd_ready_o(crdy1),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .alu_a_o(a1), .alu_b_o(b1),
        .alu_op_o(op1), .alu_out_i(out1), .res_valid_o(rv1), .res_ready_i(rr1),
        .res_data_o(rd1), .acc_o(acc1), .busy_o(busy1), .err_o(err1));

    bitwise_issuer #(.SETTLE(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(v3), .cmd_ready_o(crdy3),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .alu_a_o(a3), .alu_b_o(b3),
        .alu_op_o(op3), .alu_out_i(out3), .res_valid_o(rv3), .res_ready_i(rr3),
        .res_data_o(rd3), .acc_o(acc3), .busy_o(busy3), .err_o(err3));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command to the SETTLE=1 instance for one edge (it is always IDLE when called).
    task automatic send1(input logic [1:0] op, input logic [15:0] data);
        cmd_op = op; cmd_data = data; v1 = 1'b1;
        tick();
        v1 = 1'b0;
    endtask

    task automatic send3(input logic [1:0] op, input logic [15:0] data);
        cmd_op = op; cmd_data = data; v3 = 1'b1;
        tick();
        v3 = 1'b0;
    endtask

    task automatic chk_reset(input string pfx, input logic crdy, input logic rv, input logic busy,
                             input logic err, input logic [15:0] acc, input logic [15:0] rd,
                             input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        chk({pfx, "_acc"}, acc, 16'h0000);
        chk({pfx, "_res_data"}, rd, 16'h0000);
        chk({pfx, "_alu_a"}, a, 16'h0000);
        chk({pfx, "_alu_b"}, b, 16'h0000);
        chk({pfx, "_alu_op"}, {14'd0, op}, 16'd0);
        chk({pfx, "_res_valid"}, {15'd0, rv}, 16'd0);
        chk({pfx, "_busy"}, {15'd0, busy}, 16'd0);
        chk({pfx, "_err"}, {15'd0, err}, 16'd0);
        chk({pfx, "_cmd_ready"}, {15'd0, crdy}, 16'd1);
    endtask

    initial begin
`ifdef BITWISE_ISSUER_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        #12;
        chk_reset("rst1", crdy1, rv1, busy1, err1, acc1, rd1, a1, b1, op1);
        chk_reset("rst3", crdy3, rv3, busy3, err3, acc3, rd3, a3, b3, op3);
        rst_n = 1'b1;
        tick();

        // LOAD: acc updates on accept, no result, still ready
        send1(2'd3, 16'hF0F0);
        chk("load_acc", acc1, 16'hF0F0);
        chk("load_rv", {15'd0, rv1}, 16'd0);
        chk("load_crdy", {15'd0, crdy1}, 16'd1);

        // AND 3C3C, SETTLE=1, res_ready high
        rr1 = 1'b1;
        send1(2'd0, 16'h3C3C);
        chk("and_c1_a", a1, 16'hF0F0);
        chk("and_c1_b", b1, 16'h3C3C);
        chk("and_c1_op", {14'd0, op1}, 16'd0);
        chk("and_c1_crdy", {15'd0, crdy1}, 16'd0);
        chk("and_c1_rv", {15'd0, rv1}, 16'd0);
        tick();
        chk("and_c2_rv", {15'd0, rv1}, 16'd1);
        chk("and_c2_data", rd1, 16'h3030);
        chk("and_c2_acc", acc1, 16'h3030);
        tick();
        chk("and_c3_rv", {15'd0, rv1}, 16'd0);
        chk("and_c3_crdy", {15'd0, crdy1}, 16'd1);

        // OR 000F then INV
        send1(2'd1, 16'h000F);
        chk("or_c1_op", {14'd0, op1}, 16'd1);
        tick();
        chk("or_data", rd1, 16'h303F);
        tick();
        send1(2'd2, 16'hFFFF);
        chk("inv_c1_op", {14'd0, op1}, 16'd2);
        chk("inv_c1_b", b1, 16'h0000);
        chk("inv_c1_a", a1, 16'h303F);
        tick();
        chk("inv_data", rd1, 16'hCFC0);
        chk("inv_acc", acc1, 16'hCFC0);
        chk("inv_op_cleared", {14'd0, op1}, 16'd0);
        tick();
        chk("inv_a_held", a1, 16'h303F);
        chk("inv_idle", {15'd0, busy1}, 16'd0);

        // Backpressure on SETTLE=3: OR 1234 from acc=0
        rr3 = 1'b0;
        send3(2'd1, 16'h1234);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("bp_c%0d_rv", c), {15'd0, rv3}, 16'd0);
            chk($sformatf("bp_c%0d_crdy", c), {15'd0, crdy3}, 16'd0);
            tick();
        end
        for (int c = 4; c <= 5; c++) begin
            chk($sformatf("bp_c%0d_rv", c), {15'd0, rv3}, 16'd1);
            chk($sformatf("bp_c%0d_data", c), rd3, 16'h1234);
            chk($sformatf("bp_c%0d_crdy", c), {15'd0, crdy3}, 16'd0);
            tick();
        end
        rr3 = 1'b1;
        chk("bp_c6_rv", {15'd0, rv3}, 16'd1);
        chk("bp_c6_crdy", {15'd0, crdy3}, 16'd0);
        tick();
        chk("bp_c7_rv", {15'd0, rv3}, 16'd0);
        chk("bp_c7_crdy", {15'd0, crdy3}, 16'd1);
        chk("bp_c7_acc", acc3, 16'h1234);

        // Asynchronous reset during ISSUE
        send3(2'd3, 16'hFFFF);
        send3(2'd0, 16'h0F0F);
        tick();
        chk("mid_busy", {15'd0, busy3}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("mid", crdy3, rv3, busy3, err3, acc3, rd3, a3, b3, op3);
        #1 rst_n = 1'b1;
        tick();
        chk("post_acc", acc3, 16'h0000);
        chk("post_busy", {15'd0, busy3}, 16'd0);
        chk("post_rv", {15'd0, rv3}, 16'd0);

        // Faulty unit: returns 0 for AND F0F0 & 3C3C
        rr1 = 1'b1;
        send1(2'd3, 16'hF0F0);
        bad1 = 1'b1;
        send1(2'd0, 16'h3C3C);
        tick();
        chk("bad_data", rd1, 16'h0000);
        bad1 = 1'b0;
        tick();
        chk("bad_err", {15'd0, err1}, {15'd0, exp_err});
        send1(2'd1, 16'h0001);
        tick();
        chk("good_data", rd1, 16'h0001);
        tick();
        chk("err_sticky", {15'd0, err1}, {15'd0, exp_err});
        rst_n = 1'b0;
        #1;
        chk("err_reset", {15'd0, err1}, 16'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
